cic_gain_ctrl: RTL and testbench
================================

CIC_GAIN_CTRL -- requirements
Module: cic_gain_ctrl

Interface
REQ-001 SHALL have parameter WINDOW, default 256, giving the samples per peak-measurement window (power of two, 2..65536).
REQ-002 SHALL have parameter SETTLE, default 8, giving the samples discarded after each gain change (1..255).
REQ-003 SHALL have parameter HIGH_THR, default 1536, giving the peak at or above which gain decrements.
REQ-004 SHALL have parameter LOW_THR, default 384, giving the peak below which gain increments (LOW_THR < HIGH_THR).
REQ-005 SHALL have parameter GAIN_MAX, default 52, giving the upper gain clamp; the lower clamp is 0.
REQ-006 SHALL have parameter GAIN_INIT, default 20, giving the gain after reset (≤ GAIN_MAX).
REQ-007 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit, the reset; it is synchronous and active-high.
REQ-009 SHALL have port enable, input, 1 bit, which runs the automatic loop when high.
REQ-010 SHALL have port manual_mode, input, 1 bit, which forces manual_gain when high and overrides enable.
REQ-011 SHALL have port manual_gain, input, 8 bits, giving the gain used in manual mode.
REQ-012 SHALL have port d_in, input, signed 12 bits, carrying the CIC output sample.
REQ-013 SHALL have port d_clk, input, 1 bit, the CIC output-rate square wave; its rising edge marks a new d_in.
REQ-014 SHALL have port gain, output, 8 bits, which drives the CIC Gain input.
REQ-015 SHALL have port gain_valid, output, 1 bit, a 1-clk pulse on every change of gain.
REQ-016 SHALL have port locked, output, 1 bit, high while the last window needed no gain change.
REQ-017 SHALL have port peak, output, 11 bits, holding the peak |d_in| of the last completed window.
REQ-018 SHALL have port state, output, 2 bits, encoding IDLE=0, MEASURE=1, UPDATE=2, SETTLE=3.

Function
REQ-019 SHALL register d_clk once and generate a 1-clk sample strobe when the registered value is 0 and the current value is 1; d_in SHALL be sampled on that strobe cycle.
REQ-020 SHALL compute |d_in| in 11 bits, saturating -2048 to 2047.
REQ-021 SHALL use FSM IDLE→MEASURE when enable=1 and manual_mode=0; MEASURE→UPDATE on the strobe that completes WINDOW samples; UPDATE→SETTLE after exactly 1 clk; SETTLE→MEASURE on the strobe that completes SETTLE discarded samples.
REQ-022 In MEASURE, each strobe SHALL update the running peak to max(peak_acc, |d_in|) and increment the sample counter; the WINDOW-th sample SHALL be included in the peak.
REQ-023 In UPDATE, SHALL copy peak_acc to peak, clear peak_acc and the counter, then apply the first matching rule: peak_acc ≥ HIGH_THR and gain > 0 → gain−1; peak_acc < LOW_THR and gain < GAIN_MAX → gain+1; otherwise hold.
REQ-024 gain and gain_valid SHALL become visible together on the clk after UPDATE; gain_valid SHALL stay 0 when gain is held.
REQ-025 locked SHALL be set to 1 in UPDATE when gain is held (including a held value caused by a clamp) and cleared to 0 when gain changes; locked SHALL keep its value in MEASURE and SETTLE.
REQ-026 Strobes arriving during UPDATE SHALL be ignored and SHALL NOT be counted.
REQ-027 SETTLE SHALL count strobes only, with no peak accumulation.
REQ-028 If enable falls in any state, the FSM SHALL enter IDLE on the next clk, clear counters and peak_acc, and hold gain, peak and locked.
REQ-029 When manual_mode=1, gain SHALL equal min(manual_gain, GAIN_MAX) from the next clk, the FSM SHALL be IDLE, and locked SHALL be 0; gain_valid SHALL pulse once for each change of the applied value.
REQ-030 When manual_mode falls with enable=1, the FSM SHALL enter MEASURE from the current gain and start a fresh window.
REQ-031 If a strobe and an enable or manual_mode change occur in the same clk, the mode change SHALL win and the sample SHALL be discarded.

Reset
REQ-032 While rst=1, SHALL set gain=GAIN_INIT, gain_valid=0, locked=0, peak=0, state=IDLE, and clear all counters, peak_acc and the registered d_clk; rst SHALL take priority over every input, including mid-window.
REQ-033 After rst falls, SHALL start the first window only on a strobe observed after release.

Verification
REQ-034 Scenario: enable=1, constant d_in=1800 for 256 samples → gain goes 20→19 with one gain_valid pulse, peak=1800, locked=0, and the following 8 samples are ignored.
REQ-035 Scenario: d_in alternating ±100 with gain=GAIN_MAX → gain holds at 52, locked=1, gain_valid never pulses.
REQ-036 Scenario: d_in=-2048 for one sample in a window → peak=2047 and gain decrements.
REQ-037 Scenario: manual_mode=1, manual_gain=200 → gain=52 the next clk with a single gain_valid pulse and state=IDLE.
REQ-038 Scenario: enable dropped after 100 window samples, then re-raised → a full 256-sample window is required before UPDATE.
REQ-039 Scenario: rst asserted during SETTLE → gain=20, state=IDLE, peak=0 on the next clk.

Source files
------------

// File: rtl/cic_gain_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cic_gain_ctrl
// Brief    : Peak-measuring AGC loop that steps the CIC Gain input per window.
// Revision : 1.0
// ============================================================================
module cic_gain_ctrl #(
  parameter int unsigned WINDOW    = 256,
  parameter int unsigned SETTLE    = 8,
  parameter int unsigned HIGH_THR  = 1536,
  parameter int unsigned LOW_THR   = 384,
  parameter int unsigned GAIN_MAX  = 52,
  parameter int unsigned GAIN_INIT = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               manual_mode,
  input  logic [7:0]         manual_gain,
  input  logic signed [11:0] d_in,
  input  logic               d_clk,
  output logic [7:0]         gain,
  output logic               gain_valid,
  output logic               locked,
  output logic [10:0]        peak,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MEASURE = 2'd1,
    S_UPDATE  = 2'd2,
    S_SETTLE  = 2'd3
  } state_t;

  localparam logic [15:0] C_WIN_LAST  = 16'(WINDOW - 1);
  localparam logic [15:0] C_SET_LAST  = 16'(SETTLE - 1);
  localparam logic [11:0] C_HIGH      = 12'(HIGH_THR);
  localparam logic [11:0] C_LOW       = 12'(LOW_THR);
  localparam logic [7:0]  C_GAIN_MAX  = 8'(GAIN_MAX);
  localparam logic [7:0]  C_GAIN_INIT = 8'(GAIN_INIT);

  state_t      r_state, w_state;
  logic        r_dclk;
  logic [15:0] r_cnt, w_cnt;
  logic [10:0] r_peak_acc, w_peak_acc;
  logic [10:0] r_peak, w_peak;
  logic [7:0]  r_gain, w_gain;
  logic        r_gain_valid, w_gain_valid;
  logic        r_locked, w_locked;

  logic        w_strobe;
  logic [11:0] w_neg;
  logic [10:0] w_abs;
  logic [10:0] w_acc_max;
  logic [7:0]  w_manual_gain;

  assign w_strobe = d_clk & ~r_dclk;

  // Negating -2048 leaves bit 11 set, which is exactly the saturation case.
  assign w_neg     = 12'd0 - d_in;
  assign w_abs     = d_in[11] ? (w_neg[11] ? 11'h7FF : w_neg[10:0]) : d_in[10:0];
  assign w_acc_max = (w_abs > r_peak_acc) ? w_abs : r_peak_acc;

  assign w_manual_gain = (manual_gain > C_GAIN_MAX) ? C_GAIN_MAX : manual_gain;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_dclk       <= 1'b0;
      r_cnt        <= 16'd0;
      r_peak_acc   <= 11'd0;
      r_peak       <= 11'd0;
      r_gain       <= C_GAIN_INIT;
      r_gain_valid <= 1'b0;
      r_locked     <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_dclk       <= d_clk;
      r_cnt        <= w_cnt;
      r_peak_acc   <= w_peak_acc;
      r_peak       <= w_peak;
      r_gain       <= w_gain;
      r_gain_valid <= w_gain_valid;
      r_locked     <= w_locked;
    end
  end

  always_comb begin
    w_state      = r_state;
    w_cnt        = r_cnt;
    w_peak_acc   = r_peak_acc;
    w_peak       = r_peak;
    w_gain       = r_gain;
    w_gain_valid = 1'b0;
    w_locked     = r_locked;

    // Mode inputs are checked before any strobe so a coincident sample is dropped.
    if (manual_mode) begin
      w_state      = S_IDLE;
      w_cnt        = 16'd0;
      w_peak_acc   = 11'd0;
      w_locked     = 1'b0;
      w_gain       = w_manual_gain;
      w_gain_valid = (w_manual_gain != r_gain);
    end else if (!enable) begin
      w_state    = S_IDLE;
      w_cnt      = 16'd0;
      w_peak_acc = 11'd0;
    end else begin
      unique case (r_state)
        S_IDLE: w_state = S_MEASURE;
        S_MEASURE: begin
          if (w_strobe) begin
            w_peak_acc = w_acc_max;
            if (r_cnt == C_WIN_LAST) begin
              w_cnt   = 16'd0;
              w_state = S_UPDATE;
            end else begin
              w_cnt = r_cnt + 16'd1;
            end
          end
        end
        S_UPDATE: begin
          w_peak     = r_peak_acc;
          w_peak_acc = 11'd0;
          w_cnt      = 16'd0;
          w_state    = S_SETTLE;
          if (({1'b0, r_peak_acc} >= C_HIGH) && (r_gain != 8'd0)) begin
            w_gain       = r_gain - 8'd1;
            w_gain_valid = 1'b1;
            w_locked     = 1'b0;
          end else if (({1'b0, r_peak_acc} < C_LOW) && (r_gain < C_GAIN_MAX)) begin
            w_gain       = r_gain + 8'd1;
            w_gain_valid = 1'b1;
            w_locked     = 1'b0;
          end else begin
            w_locked = 1'b1;
          end
        end
        S_SETTLE: begin
          if (w_strobe) begin
            if (r_cnt == C_SET_LAST) begin
              w_cnt   = 16'd0;
              w_state = S_MEASURE;
            end else begin
              w_cnt = r_cnt + 16'd1;
            end
          end
        end
        default: w_state = S_IDLE;
      endcase
    end
  end

  assign gain       = r_gain;
  assign gain_valid = r_gain_valid;
  assign locked     = r_locked;
  assign peak       = r_peak;
  assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_cic_gain_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cic_gain_ctrl
// Brief    : Self-checking bench for cic_gain_ctrl against a sample-level model.
// Revision : 1.0
// ============================================================================
module tb_cic_gain_ctrl;

  localparam int WINDOW = 256, SETTLE = 8, HIGH_THR = 1536, LOW_THR = 384;
  localparam int GAIN_MAX = 52, GAIN_INIT = 20;
  localparam int P_IDLE = 0, P_MEAS = 1, P_UPD = 2, P_SET = 3;

  logic               clk = 1'b0;
  logic               rst, enable, manual_mode, d_clk;
  logic [7:0]         manual_gain;
  logic signed [11:0] d_in;
  logic [7:0]         gain;
  logic               gain_valid, locked;
  logic [10:0]        peak;
  logic [1:0]         state;

  int compared = 0, mismatched = 0, gv_pulses = 0;
  bit cmp_en = 1'b0;

  cic_gain_ctrl #(
    .WINDOW(WINDOW), .SETTLE(SETTLE), .HIGH_THR(HIGH_THR), .LOW_THR(LOW_THR),
    .GAIN_MAX(GAIN_MAX), .GAIN_INIT(GAIN_INIT)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .manual_mode(manual_mode),
    .manual_gain(manual_gain), .d_in(d_in), .d_clk(d_clk),
    .gain(gain), .gain_valid(gain_valid), .locked(locked), .peak(peak), .state(state)
  );

  always #5 clk = ~clk;

  // Model: a window is a list of |sample| values; its peak is the list maximum.
  int m_gain = GAIN_INIT, m_gv = 0, m_locked = 0, m_peak = 0, m_phase = P_IDLE;
  int m_settle_seen = 0, m_dprev = 0;
  int m_win[$];

  function automatic int sat_abs(input int v);
    if (v < 0) return (-v > 2047) ? 2047 : -v;
    return v;
  endfunction

  always @(posedge clk) begin
    int strobe, tgt, pk;
    if (rst) begin
      m_gain = GAIN_INIT; m_gv = 0; m_locked = 0; m_peak = 0; m_phase = P_IDLE;
      m_win.delete(); m_settle_seen = 0; m_dprev = 0;
    end else begin
      strobe  = (d_clk && m_dprev == 0) ? 1 : 0;
      m_dprev = d_clk ? 1 : 0;
      m_gv    = 0;
      if (manual_mode) begin
        tgt = (int'(manual_gain) > GAIN_MAX) ? GAIN_MAX : int'(manual_gain);
        m_gv = (tgt != m_gain) ? 1 : 0;
        m_gain = tgt; m_locked = 0; m_phase = P_IDLE;
        m_win.delete(); m_settle_seen = 0;
      end else if (!enable) begin
        m_phase = P_IDLE; m_win.delete(); m_settle_seen = 0;
      end else if (m_phase == P_IDLE) begin
        m_phase = P_MEAS;
      end else if (m_phase == P_MEAS) begin
        if (strobe != 0) begin
          m_win.push_back(sat_abs(int'(d_in)));
          if (m_win.size() == WINDOW) m_phase = P_UPD;
        end
      end else if (m_phase == P_UPD) begin
        pk = 0;
        foreach (m_win[i]) if (m_win[i] > pk) pk = m_win[i];
        m_peak = pk; m_win.delete(); m_settle_seen = 0; m_phase = P_SET;
        if (pk >= HIGH_THR && m_gain > 0) begin
          m_gain--; m_gv = 1; m_locked = 0;
        end else if (pk < LOW_THR && m_gain < GAIN_MAX) begin
          m_gain++; m_gv = 1; m_locked = 0;
        end else begin
          m_locked = 1;
        end
      end else begin
        if (strobe != 0) m_settle_seen++;
        if (m_settle_seen == SETTLE) begin
          m_settle_seen = 0; m_phase = P_MEAS;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      compared++;
      if (gain !== 8'(m_gain) || gain_valid !== 1'(m_gv) || locked !== 1'(m_locked) ||
          peak !== 11'(m_peak) || state !== 2'(m_phase)) begin
        mismatched++;
        if (mismatched <= 20)
          $display("FAIL cycle t=%0t dut gain=%0d gv=%0b locked=%0b peak=%0d state=%0d, model gain=%0d gv=%0d locked=%0d peak=%0d state=%0d",
                   $time, gain, gain_valid, locked, peak, state, m_gain, m_gv, m_locked, m_peak, m_phase);
      end
      if (gain_valid === 1'b1) gv_pulses++;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // One sample per 4 clk: d_clk high for 2, low for 2, d_in stable throughout.
  task automatic send(input int v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); d_in = 12'(v); d_clk = 1'b1;
      @(negedge clk);
      @(negedge clk); d_clk = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; manual_mode = 1'b0; manual_gain = 8'd0;
    d_in = 12'sd0; d_clk = 1'b0;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    chk("reset_gain", int'(gain), 20);
    chk("reset_state", int'(state), 0);
    chk("reset_peak", int'(peak), 0);

    // Loud window: 20 -> 19, then settle samples must not leak into the next peak
    rst = 1'b0; enable = 1'b1;
    repeat (2) @(negedge clk);
    gv_pulses = 0;
    send(1800, 256);
    chk("loud_gain", int'(gain), 19);
    chk("loud_peak", int'(peak), 1800);
    chk("loud_locked", int'(locked), 0);
    chk("loud_gv_pulses", gv_pulses, 1);
    send(1800, 8);
    chk("after_settle_state", int'(state), 1);
    send(50, 256);
    chk("quiet_gain", int'(gain), 20);
    chk("quiet_peak", int'(peak), 50);
    send(0, 8);

    // Manual mode clamps to GAIN_MAX
    @(negedge clk); manual_mode = 1'b1; manual_gain = 8'd200; gv_pulses = 0;
    @(negedge clk);
    chk("manual_gain", int'(gain), 52);
    chk("manual_state", int'(state), 0);
    chk("manual_gv", int'(gain_valid), 1);
    repeat (4) @(negedge clk);
    chk("manual_gv_pulses", gv_pulses, 1);

    // Leave manual: small signal at GAIN_MAX holds and locks
    manual_mode = 1'b0; gv_pulses = 0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 128; i++) begin
      send(100, 1);
      send(-100, 1);
    end
    chk("clamp_gain", int'(gain), 52);
    chk("clamp_locked", int'(locked), 1);
    chk("clamp_peak", int'(peak), 100);
    chk("clamp_gv_pulses", gv_pulses, 0);
    send(0, 8);

    // Single -2048 saturates the magnitude
    send(10, 100);
    send(-2048, 1);
    send(10, 155);
    chk("sat_peak", int'(peak), 2047);
    chk("sat_gain", int'(gain), 51);
    chk("sat_locked", int'(locked), 0);
    send(0, 8);

    // Enable drop mid-window restarts the full window
    send(1000, 100);
    @(negedge clk); enable = 1'b0;
    repeat (2) @(negedge clk);
    chk("disable_state", int'(state), 0);
    enable = 1'b1;
    repeat (2) @(negedge clk);
    send(1000, 255);
    chk("rewindow_state", int'(state), 1);
    chk("rewindow_gain", int'(gain), 51);
    send(1000, 1);
    chk("mid_gain", int'(gain), 51);
    chk("mid_locked", int'(locked), 1);
    chk("mid_peak", int'(peak), 1000);

    // Reset during SETTLE
    send(0, 3);
    chk("settle_state", int'(state), 3);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("rst_gain", int'(gain), 20);
    chk("rst_state", int'(state), 0);
    chk("rst_peak", int'(peak), 0);
    chk("rst_locked", int'(locked), 0);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    send(0, 20);
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
